// File: rtl/rocket_pool_controller.sv
// rocket_pool_controller
//   Pool of NUM_ROCKETS independent rocket slots shared by player shots and
//   invader bombs. A launch request claims the lowest-index idle slot, and
//   every flying slot advances by its speed once per startOfFrame. A slot
//   retires when its post-move pixel position leaves the legal range, or when
//   the collision logic kills it.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high; clears every slot
//   startOfFrame   one-cycle pulse per video frame; moves flying slots
//   launchReq      launch request, sampled every cycle
//   launchX/Y      signed initial top-left position, in pixels
//   launchSpeedX/Y signed speed, in 1/2^FRAC_BITS pixels per frame
//   launchAck      registered grant strobe (one cycle per grant)
//   launchSlot     granted slot index, valid with launchAck (0 otherwise)
//   poolFull       all slots are flying
//   killMask       per-slot kill request from the collision logic
//   active         per-slot flying flag
//   topLeftX/Y     packed per-slot pixel positions, slot i at [i*COORD_W +: COORD_W]
//   reachedBorder  one-cycle pulse when a slot retires at the border
//   activeCount    number of flying slots
//
// Slot FSM
//   state    | meaning
//   S_IDLE   | slot free; position held, grantable
//   S_FLYING | slot owned by a rocket; moves on startOfFrame
module rocket_pool_controller #(
  parameter int NUM_ROCKETS = 4,
  parameter int COORD_W     = 11,
  parameter int FRAC_BITS   = 6,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 469,
  localparam int SLOT_W     = (NUM_ROCKETS > 1) ? $clog2(NUM_ROCKETS) : 1,
  localparam int CNT_W      = $clog2(NUM_ROCKETS + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             startOfFrame,
  input  logic                             launchReq,
  input  logic signed [COORD_W-1:0]        launchX,
  input  logic signed [COORD_W-1:0]        launchY,
  input  logic signed [COORD_W-1:0]        launchSpeedX,
  input  logic signed [COORD_W-1:0]        launchSpeedY,
  output logic                             launchAck,
  output logic [SLOT_W-1:0]                launchSlot,
  output logic                             poolFull,
  input  logic [NUM_ROCKETS-1:0]           killMask,
  output logic [NUM_ROCKETS-1:0]           active,
  output logic [NUM_ROCKETS*COORD_W-1:0]   topLeftX,
  output logic [NUM_ROCKETS*COORD_W-1:0]   topLeftY,
  output logic [NUM_ROCKETS-1:0]           reachedBorder,
  output logic [CNT_W-1:0]                 activeCount
);

  // One guard bit above the pixel range so a rocket just past the border
  // still compares correctly before it is retired.
  localparam int PW    = COORD_W + FRAC_BITS + 1;
  localparam int PIX_W = PW - FRAC_BITS;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_FLYING = 1'b1;

  localparam logic signed [PIX_W-1:0] X_LO = PIX_W'(X_MIN);
  localparam logic signed [PIX_W-1:0] X_HI = PIX_W'(X_MAX);
  localparam logic signed [PIX_W-1:0] Y_LO = PIX_W'(Y_MIN);
  localparam logic signed [PIX_W-1:0] Y_HI = PIX_W'(Y_MAX);

  logic [0:0]                state  [NUM_ROCKETS];
  logic signed [PW-1:0]      pos_x  [NUM_ROCKETS];
  logic signed [PW-1:0]      pos_y  [NUM_ROCKETS];
  logic signed [COORD_W-1:0] spd_x  [NUM_ROCKETS];
  logic signed [COORD_W-1:0] spd_y  [NUM_ROCKETS];
  logic signed [PW-1:0]      nxt_x  [NUM_ROCKETS];
  logic signed [PW-1:0]      nxt_y  [NUM_ROCKETS];
  logic signed [PIX_W-1:0]   nxt_px [NUM_ROCKETS];
  logic signed [PIX_W-1:0]   nxt_py [NUM_ROCKETS];
  logic [NUM_ROCKETS-1:0]    exits;

  logic                      grant_vld;
  logic [SLOT_W-1:0]         grant_idx;
  logic signed [PW-1:0]      load_x;
  logic signed [PW-1:0]      load_y;

  assign load_x = {launchX[COORD_W-1], launchX, {FRAC_BITS{1'b0}}};
  assign load_y = {launchY[COORD_W-1], launchY, {FRAC_BITS{1'b0}}};

  // Candidate post-move positions; the pixel is the floor of the fixed-point
  // value, which is simply the upper bits of the two's-complement register.
  always_comb begin
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      nxt_x[i]  = pos_x[i] + {{(PW-COORD_W){spd_x[i][COORD_W-1]}}, spd_x[i]};
      nxt_y[i]  = pos_y[i] + {{(PW-COORD_W){spd_y[i][COORD_W-1]}}, spd_y[i]};
      nxt_px[i] = nxt_x[i][PW-1:FRAC_BITS];
      nxt_py[i] = nxt_y[i][PW-1:FRAC_BITS];
      exits[i]  = (nxt_px[i] < X_LO) || (nxt_px[i] > X_HI) ||
                  (nxt_py[i] < Y_LO) || (nxt_py[i] > Y_HI);
    end
  end

  // Lowest-index idle slot wins; idle means idle at the start of this cycle,
  // so a slot being killed right now is not yet grantable.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_ROCKETS - 1; i >= 0; i--) begin
      if (launchReq && state[i] == S_IDLE) begin
        grant_vld = 1'b1;
        grant_idx = SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      launchAck     <= 1'b0;
      launchSlot    <= '0;
      reachedBorder <= '0;
      for (int i = 0; i < NUM_ROCKETS; i++) begin
        state[i] <= S_IDLE;
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        spd_x[i] <= '0;
        spd_y[i] <= '0;
      end
    end else begin
      launchAck  <= grant_vld;
      launchSlot <= grant_vld ? grant_idx : '0;
      for (int i = 0; i < NUM_ROCKETS; i++) begin
        reachedBorder[i] <= 1'b0;
        case (state[i])
          S_IDLE: begin
            if (grant_vld && grant_idx == SLOT_W'(i)) begin
              state[i] <= S_FLYING;
              pos_x[i] <= load_x;
              pos_y[i] <= load_y;
              spd_x[i] <= launchSpeedX;
              spd_y[i] <= launchSpeedY;
            end
          end
          S_FLYING: begin
            // Kill takes priority over a move in the same cycle.
            if (killMask[i]) begin
              state[i] <= S_IDLE;
            end else if (startOfFrame) begin
              pos_x[i] <= nxt_x[i];
              pos_y[i] <= nxt_y[i];
              if (exits[i]) begin
                state[i]         <= S_IDLE;
                reachedBorder[i] <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    activeCount = '0;
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      active[i]                        = (state[i] == S_FLYING);
      topLeftX[i*COORD_W +: COORD_W]   = pos_x[i][FRAC_BITS +: COORD_W];
      topLeftY[i*COORD_W +: COORD_W]   = pos_y[i][FRAC_BITS +: COORD_W];
      activeCount                      = activeCount + CNT_W'(active[i]);
    end
    poolFull = &active;
  end

endmodule
